issue_credit_ctrl: RTL and testbench
====================================

# issue_credit_ctrl

Credit-based issue controller for the out-of-order core's dispatch stage. It tracks free entries in the ROB, the reservation station (RS) and the load/store buffer (LSB). It grants one instruction per cycle from the instruction fetcher only when the ROB and the target queue both have room. It also sequences recovery after a branch mispredict, and it is the single source of the fetch-side ready signal and the dispatch fire strobe.

## Interface
- `ROB_SIZE`, 16, ROB entries.
- `RS_SIZE`, 16, RS entries.
- `LSB_SIZE`, 16, LSB entries.
- `CNT_W`, 5, counter width; must hold 0..max(size).
- Reset is `rst`: synchronous, active-high. Clock is `clk`.
- `clk` in 1 — clock.
- `rst` in 1 — synchronous active-high reset.
- `rdy` in 1 — global enable; when low, all state holds and `issue_fire` = 0.
- `flush` in 1 — mispredict from ROB; discards all speculative entries.
- `lsb_keep` in CNT_W — LSB entries surviving the flush (committed stores), valid while `flush`=1.
- `if_valid` in 1 — fetcher presents an instruction.
- `if_is_mem` in 1 — presented instruction is a load or store (routes to LSB, else RS).
- `if_ready` out 1 — controller can accept this cycle.
- `issue_fire` out 1 — instruction accepted this cycle; dispatcher latches on this edge.
- `issue_to_lsb` out 1 — `if_is_mem` qualified by `issue_fire`.
- `rob_commit` in 1 — one ROB entry retired.
- `rs_release` in 1 — one RS entry dispatched to ALU.
- `lsb_release` in 1 — one LSB entry completed.
- `rob_free`, `rs_free`, `lsb_free` out CNT_W — current free-entry credits.
- `credit_err` out 1 — sticky; set when a release would exceed a size.

## Operation
- States: RUN, RECOVER. Reset goes to RUN with `rob_free`=ROB_SIZE, `rs_free`=RS_SIZE, `lsb_free`=LSB_SIZE, `credit_err`=0.
- `room` = `rob_free`≥1 && (`if_is_mem` ? `lsb_free`≥1 : `rs_free`≥1).
- `if_ready` = state==RUN && `room` && !`flush`. This is combinational from registers and inputs.
- `issue_fire` = `if_ready` && `if_valid` && `rdy`.
- Credit update in RUN with `rdy`=1 and `flush`=0 uses `next = free - fire_to_queue + release`, computed per counter:
  - ROB: decremented by `issue_fire`, incremented by `rob_commit`.
  - RS: decremented by `issue_fire`&&!`if_is_mem`, incremented by `rs_release`.
  - LSB: decremented by `issue_fire`&&`if_is_mem`, incremented by `lsb_release`.
  - Simultaneous issue and release on the same counter gives a net change of 0.
- Overflow: if `next` > size, the counter saturates at size and `credit_err` is set. Only `rst` clears `credit_err`.
- `flush`=1 with `rdy`=1, from any state:
  - Next cycle `rob_free`=ROB_SIZE, `rs_free`=RS_SIZE, `lsb_free`=LSB_SIZE−`lsb_keep`.
  - All releases and issue in the flush cycle are ignored; `lsb_keep` already accounts for them.
  - State goes to RECOVER.
- RECOVER: `if_ready`=0 for exactly one cycle while the fetcher redirects, then back to RUN. Releases are counted normally in RECOVER. A `flush` in RECOVER re-applies the flush rules and stays in RECOVER.
- `rdy`=0: counters, state and `credit_err` hold; all inputs are ignored.

## Timing
- Issue is zero-latency: `issue_fire` is asserted in the same cycle as `if_valid`. Credits reflect the issue from the next edge.
- Releases are visible in `*_free` one cycle after assertion. A credit freed in cycle t can be used by an issue in cycle t+1, not in t.
- Flush at edge t: credits are restored at t+1, `if_ready`=0 during t+1 (RECOVER), and the earliest new issue is in cycle t+2.
- Full boundary: with `rob_free`=1, one issue drives it to 0 and `if_ready`=0 the next cycle. If there is also a `rob_commit` in that cycle, it stays at 1 and `if_ready` stays 1.
- Empty boundary: release at size (with no matching issue) triggers saturation and `credit_err`.
- Reset mid-operation overrides `flush` and `rdy`. All credits are full one cycle later.

## Test plan
- Fill ROB: issue 16 ALU instructions back-to-back with no commits. Expect `rob_free` to go 16→0 and `if_ready`=0 at cycle 17. Then issue a single `rob_commit` and expect `rob_free`=1 and `if_ready`=1 one cycle later.
- Queue routing: with `rs_free`=0 and `lsb_free`=3, `if_is_mem`=0 gives `if_ready`=0, while `if_is_mem`=1 gives `issue_fire`=1, `issue_to_lsb`=1 and `lsb_free`=2 next.
- Simultaneous: `rs_free`=0, `rs_release`=1 with an ALU issue blocked that cycle. Next cycle `rs_free`=1. Then issue plus release in the same cycle holds `rs_free`=1.
- Flush: credits 5/7/2, `flush`=1, `lsb_keep`=4, with `lsb_release`=1 in the same cycle. Next credits are 16/16/12, `if_ready`=0 for one cycle, and the first issue is at t+2.
- `rdy`=0 for 3 cycles with `if_valid`, commits and releases asserted: no `issue_fire`, and all counters are unchanged.
- Overflow: `rob_free`=16 and `rob_commit`=1 keeps `rob_free` at 16 and latches `credit_err`=1. `credit_err` survives a flush and clears only on `rst`.

Source files
------------

// File: rtl/issue_credit_ctrl_if.sv
// Dispatch-side bundle between the fetcher/ROB/queues and the issue credit controller.
interface issue_credit_ctrl_if #(
   parameter int CNT_W = 5
);
   logic             rdy;
   logic             flush;
   logic [CNT_W-1:0] lsb_keep;
   logic             if_valid;
   logic             if_is_mem;
   logic             if_ready;
   logic             issue_fire;
   logic             issue_to_lsb;
   logic             rob_commit;
   logic             rs_release;
   logic             lsb_release;
   logic [CNT_W-1:0] rob_free;
   logic [CNT_W-1:0] rs_free;
   logic [CNT_W-1:0] lsb_free;
   logic             credit_err;

   // Controller side.
   modport slave (
      input  rdy, flush, lsb_keep, if_valid, if_is_mem,
             rob_commit, rs_release, lsb_release,
      output if_ready, issue_fire, issue_to_lsb,
             rob_free, rs_free, lsb_free, credit_err
   );

   // Environment side (fetcher, ROB, RS, LSB).
   modport master (
      output rdy, flush, lsb_keep, if_valid, if_is_mem,
             rob_commit, rs_release, lsb_release,
      input  if_ready, issue_fire, issue_to_lsb,
             rob_free, rs_free, lsb_free, credit_err
   );
endinterface

// File: rtl/issue_credit_ctrl.sv
// Credit-based issue controller: tracks ROB/RS/LSB free entries, grants one
// instruction per cycle when the ROB and its target queue have room, and
// sequences a one-cycle recovery bubble after a mispredict flush.
module issue_credit_ctrl #(
   parameter int ROB_SIZE = 16,
   parameter int RS_SIZE  = 16,
   parameter int LSB_SIZE = 16,
   parameter int CNT_W    = 5
) (
   input logic              clk,
   input logic              rst,
   issue_credit_ctrl_if.slave bus_if
);

   typedef enum logic {RUN, RECOVER} state_t;

   localparam logic [CNT_W:0]   ROB_MAX = (CNT_W+1)'(ROB_SIZE);
   localparam logic [CNT_W:0]   RS_MAX  = (CNT_W+1)'(RS_SIZE);
   localparam logic [CNT_W:0]   LSB_MAX = (CNT_W+1)'(LSB_SIZE);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] rob_free_q, rob_free_d;
   logic [CNT_W-1:0] rs_free_q, rs_free_d;
   logic [CNT_W-1:0] lsb_free_q, lsb_free_d;
   logic             credit_err_q, credit_err_d;

   logic             room;
   logic             if_ready;
   logic             issue_fire;
   logic [CNT_W:0]   rob_nxt, rs_nxt, lsb_nxt;

   // One extra bit so a release at full size is visible as an overflow.
   function automatic logic [CNT_W:0] credit_next(input logic [CNT_W-1:0] free,
                                                  input logic dec, input logic inc);
      return {1'b0, free} - {{CNT_W{1'b0}}, dec} + {{CNT_W{1'b0}}, inc};
   endfunction

   // Handshake: room in the ROB and in the queue the instruction routes to.
   always_comb begin
      room       = (rob_free_q != '0) &&
                   (bus_if.if_is_mem ? (lsb_free_q != '0) : (rs_free_q != '0));
      if_ready   = (state_q == RUN) && room && !bus_if.flush;
      issue_fire = if_ready && bus_if.if_valid && bus_if.rdy;
   end

   // Next-state and credit arithmetic; flush restores credits, rdy=0 holds all.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      state_d      = state_q;
      rob_free_d   = rob_free_q;
      rs_free_d    = rs_free_q;
      lsb_free_d   = lsb_free_q;
      credit_err_d = credit_err_q;
      rob_nxt      = credit_next(rob_free_q, issue_fire, bus_if.rob_commit);
      rs_nxt       = credit_next(rs_free_q, issue_fire && !bus_if.if_is_mem, bus_if.rs_release);
      lsb_nxt      = credit_next(lsb_free_q, issue_fire && bus_if.if_is_mem, bus_if.lsb_release);

      if (bus_if.rdy) begin
         if (bus_if.flush) begin
            // Releases and issue this cycle are already folded into lsb_keep.
            state_d    = RECOVER;
            rob_free_d = ROB_MAX[CNT_W-1:0];
            rs_free_d  = RS_MAX[CNT_W-1:0];
            lsb_free_d = LSB_MAX[CNT_W-1:0] - bus_if.lsb_keep;
         end else begin
            // RECOVER lasts exactly one cycle; issue_fire is already 0 there.
            state_d = RUN;
            if (rob_nxt > ROB_MAX) begin
               rob_free_d   = ROB_MAX[CNT_W-1:0];
               credit_err_d = 1'b1;
            end else begin
               rob_free_d = rob_nxt[CNT_W-1:0];
            end
            if (rs_nxt > RS_MAX) begin
               rs_free_d    = RS_MAX[CNT_W-1:0];
               credit_err_d = 1'b1;
            end else begin
               rs_free_d = rs_nxt[CNT_W-1:0];
            end
            if (lsb_nxt > LSB_MAX) begin
               lsb_free_d   = LSB_MAX[CNT_W-1:0];
               credit_err_d = 1'b1;
            end else begin
               lsb_free_d = lsb_nxt[CNT_W-1:0];
            end
         end
      end
   end

   // State and credit registers with synchronous reset to full credits.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q      <= RUN;
         rob_free_q   <= ROB_MAX[CNT_W-1:0];
         rs_free_q    <= RS_MAX[CNT_W-1:0];
         lsb_free_q   <= LSB_MAX[CNT_W-1:0];
         credit_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rob_free_q   <= rob_free_d;
         rs_free_q    <= rs_free_d;
         lsb_free_q   <= lsb_free_d;
         credit_err_q <= credit_err_d;
      end
   end

   assign bus_if.if_ready     = if_ready;
   assign bus_if.issue_fire   = issue_fire;
   assign bus_if.issue_to_lsb = issue_fire && bus_if.if_is_mem;
   assign bus_if.rob_free     = rob_free_q;
   assign bus_if.rs_free      = rs_free_q;
   assign bus_if.lsb_free     = lsb_free_q;
   assign bus_if.credit_err   = credit_err_q;

endmodule

// File: tb/tb_issue_credit_ctrl.sv
// Directed scenarios plus randomized traffic against an integer credit model.
module tb_issue_credit_ctrl;

   localparam int SZ    = 16;
   localparam int CNT_W = 5;

   logic clk;
   logic rst;

   issue_credit_ctrl_if #(.CNT_W(CNT_W)) bus ();

   issue_credit_ctrl #(
      .ROB_SIZE(SZ), .RS_SIZE(SZ), .LSB_SIZE(SZ), .CNT_W(CNT_W)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_if (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    n_checks = 0;
   int    n_fail   = 0;
   string phase    = "init";

   // Reference model: plain integer credits and a pending-bubble flag.
   int m_rob, m_rs, m_lsb;
   bit m_err, m_bubble;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s/%s: got %0d expected %0d", phase, tag, obs, exp);
      end
   endtask

   // One cycle: drive at posedge+1, check at negedge+1, advance model, return at posedge+1.
   task automatic step(input bit r, input bit rd, input bit fl, input int keep,
                       input bit v, input bit m, input bit c, input bit rsr, input bit lr);
      bit e_ready, e_fire;
      int d_rob, d_rs, d_lsb;
      rst             = r;
      bus.rdy         = rd;
      bus.flush       = fl;
      bus.lsb_keep    = CNT_W'(keep);
      bus.if_valid    = v;
      bus.if_is_mem   = m;
      bus.rob_commit  = c;
      bus.rs_release  = rsr;
      bus.lsb_release = lr;
      @(negedge clk);
      #1;
      e_ready = !m_bubble && !fl && m_rob > 0 && (m ? m_lsb > 0 : m_rs > 0);
      e_fire  = e_ready && v && rd;
      check("if_ready", 32'(bus.if_ready), 32'(e_ready));
      check("issue_fire", 32'(bus.issue_fire), 32'(e_fire));
      check("issue_to_lsb", 32'(bus.issue_to_lsb), 32'(e_fire && m));
      check("rob_free", 32'(bus.rob_free), 32'(m_rob));
      check("rs_free", 32'(bus.rs_free), 32'(m_rs));
      check("lsb_free", 32'(bus.lsb_free), 32'(m_lsb));
      check("credit_err", 32'(bus.credit_err), 32'(m_err));
      if (r) begin
         m_rob = SZ; m_rs = SZ; m_lsb = SZ; m_err = 0; m_bubble = 0;
      end else if (rd) begin
         if (fl) begin
            m_rob = SZ; m_rs = SZ; m_lsb = SZ - keep; m_bubble = 1;
         end else begin
            m_bubble = 0;
            d_rob = m_rob - int'(e_fire) + int'(c);
            d_rs  = m_rs - int'(e_fire && !m) + int'(rsr);
            d_lsb = m_lsb - int'(e_fire && m) + int'(lr);
            if (d_rob > SZ) begin d_rob = SZ; m_err = 1; end
            if (d_rs > SZ)  begin d_rs = SZ;  m_err = 1; end
            if (d_lsb > SZ) begin d_lsb = SZ; m_err = 1; end
            m_rob = d_rob; m_rs = d_rs; m_lsb = d_lsb;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(0, 1, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      step(1, 1, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst             = 1'b1;
      bus.rdy         = 1'b0;
      bus.flush       = 1'b0;
      bus.lsb_keep    = '0;
      bus.if_valid    = 1'b0;
      bus.if_is_mem   = 1'b0;
      bus.rob_commit  = 1'b0;
      bus.rs_release  = 1'b0;
      bus.lsb_release = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      m_rob = SZ; m_rs = SZ; m_lsb = SZ; m_err = 0; m_bubble = 0;

      phase = "reset";
      do_reset();
      idle();
      check("rob_full", 32'(bus.rob_free), 32'(SZ));
      check("err_clear", 32'(bus.credit_err), 32'd0);

      // Fill the ROB with 16 ALU instructions, then free one slot.
      phase = "fill_rob";
      for (int i = 0; i < SZ; i++) step(0, 1, 0, 0, 1, 0, 0, 0, 0);
      check("rob_empty", 32'(bus.rob_free), 32'd0);
      step(0, 1, 0, 0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 1, 1, 0);
      check("rob_one", 32'(bus.rob_free), 32'd1);
      check("ready_again", 32'(bus.if_ready), 32'd1);

      // rs_free=0 and lsb_free=3, then route by if_is_mem.
      phase = "routing";
      do_reset();
      for (int i = 0; i < SZ; i++) step(0, 1, 0, 0, 1, 0, 1, 0, 0);
      for (int i = 0; i < 13; i++) step(0, 1, 0, 0, 1, 1, 1, 0, 0);
      check("rs_zero", 32'(bus.rs_free), 32'd0);
      check("lsb_three", 32'(bus.lsb_free), 32'd3);
      step(0, 1, 0, 0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 1, 1, 0, 0, 0);
      check("lsb_two", 32'(bus.lsb_free), 32'd2);

      // Release at rs_free=0 while ALU blocked, then issue plus release.
      phase = "simultaneous";
      step(0, 1, 0, 0, 1, 0, 0, 1, 0);
      check("rs_one", 32'(bus.rs_free), 32'd1);
      step(0, 1, 0, 0, 1, 0, 0, 1, 0);
      check("rs_hold", 32'(bus.rs_free), 32'd1);

      // Reach 5/7/2, flush with lsb_keep=4 and a same-cycle lsb_release.
      phase = "flush";
      do_reset();
      for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 14; i++) step(0, 1, 0, 0, 1, 1, i < 12, 0, 0);
      check("pre_rob", 32'(bus.rob_free), 32'd5);
      check("pre_rs", 32'(bus.rs_free), 32'd7);
      check("pre_lsb", 32'(bus.lsb_free), 32'd2);
      step(0, 1, 1, 4, 1, 0, 0, 0, 1);
      check("post_rob", 32'(bus.rob_free), 32'd16);
      check("post_rs", 32'(bus.rs_free), 32'd16);
      check("post_lsb", 32'(bus.lsb_free), 32'd12);
      check("bubble", 32'(bus.if_ready), 32'd0);
      step(0, 1, 0, 0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 1, 0, 0, 0, 0);
      check("first_issue", 32'(bus.rob_free), 32'd15);

      // Global stall holds everything.
      phase = "rdy_low";
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, i[0], 1, 1, 1);
      check("rob_held", 32'(bus.rob_free), 32'd15);
      idle();

      // Overflow latches credit_err until reset.
      phase = "overflow";
      do_reset();
      step(0, 1, 0, 0, 0, 0, 1, 0, 0);
      check("rob_sat", 32'(bus.rob_free), 32'(SZ));
      check("err_set", 32'(bus.credit_err), 32'd1);
      step(0, 1, 1, 0, 0, 0, 0, 0, 0);
      check("err_after_flush", 32'(bus.credit_err), 32'd1);
      do_reset();
      check("err_cleared", 32'(bus.credit_err), 32'd0);

      // Randomized traffic; releases mostly only when an entry is in use.
      phase = "random";
      for (int i = 0; i < 3000; i++) begin
         bit r, rd, fl, v, m, c, rsr, lr;
         int keep;
         r    = ($urandom_range(0, 299) == 0);
         rd   = ($urandom_range(0, 9) < 8);
         fl   = ($urandom_range(0, 24) == 0);
         keep = $urandom_range(0, SZ);
         v    = ($urandom_range(0, 3) != 0);
         m    = $urandom_range(0, 1);
         c    = (m_rob < SZ) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 199) == 0);
         rsr  = (m_rs  < SZ) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 199) == 0);
         lr   = (m_lsb < SZ) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 199) == 0);
         step(r, rd, fl, keep, v, m, c, rsr, lr);
      end
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
